// File: rtl/mem_arb_pkg.sv
// Shared state encoding and default widths for the memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    ME_ACC,
    ME_RSP,
    IF_HI,
    IF_LO,
    IF_RSP
  } state_t;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way request picker: fixed data-stage priority, or alternating on contention
// when MEM_ARB_RR_EN is defined (last_if = 1 means fetch won the last contention).
module arb_pick (
  input  logic me_req,
  input  logic if_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_if,
`endif
  output logic grant_me,
  output logic grant_if
);

  always_comb begin
    grant_me = me_req;
    grant_if = if_req && !me_req;
`ifdef MEM_ARB_RR_EN
    if (me_req && if_req) begin
      grant_me = last_if;
      grant_if = !last_if;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port (two-word instruction) and a data port onto one
// single-port synchronous-read memory. Define MEM_ARB_RR_EN for alternating priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic                if_abort,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_valid,
  output logic [2*DATA_W-1:0] if_instr,
  output logic                if_wait,
  input  logic                me_req,
  input  logic                me_wr,
  input  logic [ADDR_W-1:0]   me_addr,
  input  logic [DATA_W-1:0]   me_wdata,
  output logic                me_valid,
  output logic [DATA_W-1:0]   me_rdata,
  output logic                me_wait,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] hi_q;
  logic              grant_me, grant_if;

`ifdef MEM_ARB_RR_EN
  logic last_if;
`endif

  arb_pick u_pick (
    .me_req   (me_req),
    .if_req   (if_req),
`ifdef MEM_ARB_RR_EN
    .last_if  (last_if),
`endif
    .grant_me (grant_me),
    .grant_if (grant_if)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      hi_q    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (grant_me) begin
          addr_q  <= me_addr;
          wr_q    <= me_wr;
          wdata_q <= me_wdata;
        end else if (grant_if) begin
          addr_q  <= if_addr;
          wr_q    <= 1'b0;
          wdata_q <= '0;
        end
      end
      // The high word read in IF_HI is on mem_rdata throughout IF_LO.
      if (state == IF_LO && !if_abort) hi_q <= mem_rdata;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Pointer moves only when both ports compete, so a lone request never steals a turn.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_if <= 1'b1;
    else if (state == IDLE && me_req && if_req) last_if <= grant_if;
  end
`endif

  always_comb begin
    state_n   = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    if_instr  = '0;
    me_valid  = 1'b0;
    me_rdata  = '0;
    case (state)
      IDLE: begin
        if (grant_me)      state_n = ME_ACC;
        else if (grant_if) state_n = IF_HI;
      end
      ME_ACC: begin
        mem_en    = 1'b1;
        mem_we    = wr_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_n   = ME_RSP;
      end
      ME_RSP: begin
        me_valid = 1'b1;
        me_rdata = wr_q ? '0 : mem_rdata;
        state_n  = IDLE;
      end
      IF_HI: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        state_n  = if_abort ? IDLE : IF_LO;
      end
      IF_LO: begin
        mem_en   = 1'b1;
        mem_addr = addr_q + ADDR_W'(1);
        state_n  = if_abort ? IDLE : IF_RSP;
      end
      IF_RSP: begin
        if_valid = 1'b1;
        if_instr = {hi_q, mem_rdata};
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign if_wait = rst && if_req && !if_valid;
  assign me_wait = rst && me_req && !me_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences, and a
// randomized run against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, if_valid, if_wait;
  logic [31:0] if_addr, if_instr;
  logic        me_req, me_wr, me_valid, me_wait;
  logic [31:0] me_addr;
  logic [15:0] me_wdata, me_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [256];
  logic        pre_we;
  logic [31:0] pre_addr;
  logic [15:0] pre_data;

  logic [15:0] ref_mem [logic [31:0]];
  bit          model_last_if;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    bit          is_if;
    bit          wr;
    bit          pre;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [15:0] p0;
    logic [15:0] p1;
    int          lat;
    logic [31:0] data;
    int          we;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  vec_t vt[6];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_abort (if_abort),
    .if_addr  (if_addr),
    .if_valid (if_valid),
    .if_instr (if_instr),
    .if_wait  (if_wait),
    .me_req   (me_req),
    .me_wr    (me_wr),
    .me_addr  (me_addr),
    .me_wdata (me_wdata),
    .me_valid (me_valid),
    .me_rdata (me_rdata),
    .me_wait  (me_wait),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous-read memory, indexed by the low address byte.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr[7:0]] <= pre_data;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drive one or two requests from an idle arbiter and record what comes back.
  task automatic run_pair(input bit do_me, input bit do_if, input bit wr,
                          input logic [31:0] ma, input logic [15:0] wd, input logic [31:0] fa,
                          output int me_cyc, output logic [15:0] me_d,
                          output int if_cyc, output logic [31:0] if_d,
                          output int we_cnt, output logic [31:0] a0, output logic [31:0] a1,
                          output int bad);
    int cyc, nr;
    me_cyc = 0; if_cyc = 0; me_d = '0; if_d = '0;
    we_cnt = 0; a0 = '0; a1 = '0; bad = 0; cyc = 0; nr = 0;
    @(negedge clk);
    me_req = do_me; me_wr = wr; me_addr = ma; me_wdata = wd;
    if_req = do_if; if_addr = fa;
    while ((me_req || if_req) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (me_wait !== (me_req && !me_valid)) bad++;
      if (if_wait !== (if_req && !if_valid)) bad++;
      if ((me_valid && !me_req) || (if_valid && !if_req)) bad++;
      if (mem_en && mem_we) we_cnt++;
      if (mem_en && !mem_we) begin
        if (nr == 0) a0 = mem_addr;
        else if (nr == 1) a1 = mem_addr;
        nr++;
      end
      if (me_valid && me_req) begin me_cyc = cyc; me_d = me_rdata; me_req = 1'b0; end
      if (if_valid && if_req) begin if_cyc = cyc; if_d = if_instr; if_req = 1'b0; end
    end
    me_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic me_step(input bit wr, input logic [31:0] ma, input logic [15:0] wd,
                         output logic [15:0] d);
    if (wr) begin ref_mem[ma] = wd; d = 16'h0; end
    else d = ref_rd(ma);
  endtask

  // Transaction-level expectation: the winner finishes first, the loser starts
  // in the idle cycle after the winner's valid pulse.
  task automatic check_pair(input string tag, input bit do_me, input bit do_if, input bit wr,
                            input logic [31:0] ma, input logic [15:0] wd, input logic [31:0] fa,
                            output int me_cyc, output int if_cyc);
    int we_cnt, bad, exp_me, exp_if;
    logic [15:0] me_d, exp_md;
    logic [31:0] if_d, a0, a1, exp_id;
    bit me_first;
    me_first = do_me;
    if (do_me && do_if) begin
`ifdef MEM_ARB_RR_EN
      me_first = model_last_if;
      model_last_if = !me_first;
`else
      me_first = 1'b1;
`endif
    end
    exp_me = (do_if && !me_first) ? 3 + 1 + 2 : 2;
    exp_if = (do_me && me_first) ? 2 + 1 + 3 : 3;
    exp_md = '0; exp_id = '0;
    if (do_me && me_first) me_step(wr, ma, wd, exp_md);
    if (do_if) exp_id = {ref_rd(fa), ref_rd(fa + 32'd1)};
    if (do_me && !me_first) me_step(wr, ma, wd, exp_md);
    run_pair(do_me, do_if, wr, ma, wd, fa, me_cyc, me_d, if_cyc, if_d, we_cnt, a0, a1, bad);
    if (do_me) begin
      check({tag, " me latency"}, 32'(me_cyc), 32'(exp_me));
      check({tag, " me_rdata"}, {16'h0, me_d}, {16'h0, exp_md});
    end
    if (do_if) begin
      check({tag, " if latency"}, 32'(if_cyc), 32'(exp_if));
      check({tag, " if_instr"}, if_d, exp_id);
    end
    check({tag, " write cycles"}, 32'(we_cnt), (do_me && wr) ? 32'd1 : 32'd0);
    check({tag, " wait/valid rule"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int me_cyc, if_cyc, we_cnt, bad, seen;
    logic [15:0] me_d;
    logic [31:0] if_d, a0, a1;

    rst = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    if_req = 1'b1; if_abort = 1'b0; if_addr = 32'h20;
    me_req = 1'b1; me_wr = 1'b1; me_addr = 32'h10; me_wdata = 16'h1234;
    model_last_if = 1'b1;

    repeat (3) @(negedge clk);
    check("reset mem_en", {31'h0, mem_en}, 32'h0);
    check("reset mem_we", {31'h0, mem_we}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", {16'h0, mem_wdata}, 32'h0);
    check("reset if_valid", {31'h0, if_valid}, 32'h0);
    check("reset if_instr", if_instr, 32'h0);
    check("reset if_wait", {31'h0, if_wait}, 32'h0);
    check("reset me_valid", {31'h0, me_valid}, 32'h0);
    check("reset me_rdata", {16'h0, me_rdata}, 32'h0);
    check("reset me_wait", {31'h0, me_wait}, 32'h0);
    if_req = 1'b0; me_req = 1'b0; me_wr = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    vt[0] = '{0, 0, 1, 32'h10, 16'h0, 16'hBEEF, 16'h0, 2, 32'h0000BEEF, 0, 32'h10, 32'h0};
    vt[1] = '{1, 0, 1, 32'h20, 16'h0, 16'h1234, 16'h5678, 3, 32'h12345678, 0, 32'h20, 32'h21};
    vt[2] = '{0, 1, 0, 32'h30, 16'hA5A5, 16'h0, 16'h0, 2, 32'h0, 1, 32'h0, 32'h0};
    vt[3] = '{0, 0, 0, 32'h30, 16'h0, 16'h0, 16'h0, 2, 32'h0000A5A5, 0, 32'h30, 32'h0};
    vt[4] = '{1, 0, 1, 32'hFFFFFFFF, 16'h0, 16'hCAFE, 16'hF00D, 3, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 32'h0};
    vt[5] = '{0, 0, 0, 32'h0, 16'h0, 16'h0, 16'h0, 2, 32'h0000F00D, 0, 32'h0, 32'h0};

    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vt[i].pre) begin
        preload(vt[i].addr, vt[i].p0);
        if (vt[i].is_if) preload(vt[i].addr + 32'd1, vt[i].p1);
      end
      run_pair(!vt[i].is_if, vt[i].is_if, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].addr,
               me_cyc, me_d, if_cyc, if_d, we_cnt, a0, a1, bad);
      if (!vt[i].is_if && vt[i].wr) ref_mem[vt[i].addr] = vt[i].wdata;
      check({nm, " latency"}, 32'(vt[i].is_if ? if_cyc : me_cyc), 32'(vt[i].lat));
      check({nm, " data"}, vt[i].is_if ? if_d : {16'h0, me_d}, vt[i].data);
      check({nm, " write cycles"}, 32'(we_cnt), 32'(vt[i].we));
      check({nm, " wait/valid rule"}, 32'(bad), 32'h0);
      if (!vt[i].wr) check({nm, " first read addr"}, a0, vt[i].a0);
      if (vt[i].is_if) check({nm, " second read addr"}, a1, vt[i].a1);
    end

    check_pair("contend1", 1, 1, 0, 32'h10, 16'h0, 32'h20, me_cyc, if_cyc);
    check("contend1 data-first me", 32'(me_cyc), 32'd2);
    check("contend1 data-first if", 32'(if_cyc), 32'd6);
    check_pair("contend2", 1, 1, 0, 32'h10, 16'h0, 32'h20, me_cyc, if_cyc);
`ifdef MEM_ARB_RR_EN
    check("contend2 fetch-first if", 32'(if_cyc), 32'd3);
    check("contend2 fetch-first me", 32'(me_cyc), 32'd6);
`else
    check("contend2 data-first me", 32'(me_cyc), 32'd2);
    check("contend2 data-first if", 32'(if_cyc), 32'd6);
`endif

    // Abort in IF_LO with a data request waiting behind it.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("abort IF_HI addr", mem_addr, 32'h40);
    @(negedge clk);
    check("abort IF_LO addr", mem_addr, 32'h41);
    if_abort = 1'b1; if_req = 1'b0;
    me_req = 1'b1; me_wr = 1'b0; me_addr = 32'h10;
    @(negedge clk);
    if_abort = 1'b0;
    check("abort idle mem_en", {31'h0, mem_en}, 32'h0);
    check("abort no if_valid", {31'h0, if_valid}, 32'h0);
    @(negedge clk);
    check("abort me accepted", {mem_addr[30:0], mem_en}, {31'h10, 1'b1});
    @(negedge clk);
    check("abort me_valid", {31'h0, me_valid}, 32'h1);
    check("abort me_rdata", {16'h0, me_rdata}, 32'h0000BEEF);
    me_req = 1'b0;

    // Reset asserted while the fetch is in IF_LO.
    preload(32'h50, 16'h1111);
    preload(32'h51, 16'h2222);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h50;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst mem_en", {31'h0, mem_en}, 32'h0);
    check("midrst mem_addr", mem_addr, 32'h0);
    check("midrst if_wait", {31'h0, if_wait}, 32'h0);
    check("midrst if_valid", {31'h0, if_valid}, 32'h0);
    if_req = 1'b0;
    model_last_if = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_valid) seen++;
    end
    check("midrst no if_valid after release", 32'(seen), 32'h0);
    check_pair("midrst refetch", 0, 1, 0, 32'h0, 16'h0, 32'h50, me_cyc, if_cyc);

    for (int a = 32'h80; a <= 32'h90; a++) preload(32'(a), 16'($urandom));
    for (int i = 0; i < 60; i++) begin
      int mode;
      logic [31:0] ma, fa;
      mode = $urandom_range(0, 2);
      ma = 32'h80 + 32'($urandom_range(0, 15));
      fa = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'h80 + 32'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      check_pair($sformatf("rand%0d", i), mode != 1, mode != 0, 1'($urandom_range(0, 1)),
                 ma, 16'($urandom), fa, me_cyc, if_cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
